// File: rtl/irq_dispatch_ctrl_pkg.sv
// Shared types and helpers for the interrupt dispatch sequencer.
// Optional rotating priority: define IRQ_ROUND_ROBIN_EN.
package irq_pkg;

  localparam int NUM_IRQ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  function automatic int irq_num(int idx, int n);
    return n - 1 - idx;
  endfunction

endpackage

// File: rtl/irq_dispatch_ctrl_if.sv
// CPU-side interrupt handshake: present/ack, then service/eoi.
// master = dispatcher, slave = CPU.
interface irq_dispatch_ctrl_if #(
  parameter int NUM_IRQ = 4
);
  localparam int ID_W = $clog2(NUM_IRQ);

  logic            int_valid;
  logic [ID_W-1:0] int_id;
  logic            in_service;
  logic            int_ack;
  logic            int_eoi;

  modport master (
    output int_valid,
    output int_id,
    output in_service,
    input  int_ack,
    input  int_eoi
  );

  modport slave (
    input  int_valid,
    input  int_id,
    input  in_service,
    output int_ack,
    output int_eoi
  );
endinterface

// File: rtl/irq_dispatch_ctrl_prio_enc.sv
// First set bit of req at or after start, wrapping modulo N.
// A start of zero gives plain lowest-index priority.
module irq_prio_enc #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] id
);

  logic [W-1:0] idx;

  always_comb begin
    found = 1'b0;
    id    = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = W'((int'(start) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        id    = idx;
      end
    end
  end

endmodule

// File: rtl/irq_dispatch_ctrl.sv
// Interrupt dispatch sequencer: edge latch, mask, priority select, ack/eoi FSM.
// Define IRQ_ROUND_ROBIN_EN for rotating priority after each ack.
module irq_dispatch_ctrl
  import irq_pkg::*;
#(
  parameter  int NUM_IRQ = NUM_IRQ_DEF,
  localparam int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_data,
  irq_dispatch_ctrl_if.master cpu,
  output logic [NUM_IRQ-1:0] pending_q,
  output logic [NUM_IRQ-1:0] mask_q
);

  state_t state_q, state_d;

  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    sel_id;
  logic [ID_W-1:0]    start;
  logic [NUM_IRQ-1:0] irq_d;
  logic [NUM_IRQ-1:0] act;
  logic [NUM_IRQ-1:0] req_n;
  logic [NUM_IRQ-1:0] id_oh_n;
  logic [NUM_IRQ-1:0] id_oh_b;
  logic [NUM_IRQ-1:0] clr;
  logic               found;
  logic               ack_fire;
  logic               still_en;
  logic               valid;
  logic               in_svc;

  // irq bit order is reversed w.r.t. IRQ numbers
  assign act     = pending_q & mask_q;
  assign id_oh_n = NUM_IRQ'(1) << id_q;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_map
    assign req_n[irq_num(i, NUM_IRQ)] = act[i];
    assign id_oh_b[i] = id_oh_n[irq_num(i, NUM_IRQ)];
  end

  assign still_en = |(id_oh_b & mask_q);
  assign clr      = ack_fire ? id_oh_b : '0;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_id;

  always_ff @(posedge clk) begin
    if (reset)
      last_id <= ID_W'(NUM_IRQ - 1);
    else if (ack_fire)
      last_id <= id_q;
  end

  assign start = ID_W'((int'(last_id) + 1) % NUM_IRQ);
`else
  assign start = '0;
`endif

  irq_prio_enc #(
    .N (NUM_IRQ)
  ) u_enc (
    .req   (req_n),
    .start (start),
    .found (found),
    .id    (sel_id)
  );

  // lines high across reset release must not pend
  always_ff @(posedge clk) begin
    irq_d <= irq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      id_q      <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      pending_q <= (pending_q & ~clr) | (irq & ~irq_d);
      if (mask_wr)
        mask_q <= mask_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    ack_fire = 1'b0;
    valid    = 1'b0;
    in_svc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          id_d    = sel_id;
          state_d = REQ;
        end
      end
      REQ: begin
        valid = 1'b1;
        if (cpu.int_ack) begin
          ack_fire = 1'b1;
          state_d  = SERVICE;
        end else if (!still_en) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        in_svc = 1'b1;
        if (cpu.int_eoi)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu.int_valid  = valid;
  assign cpu.int_id     = id_q;
  assign cpu.in_service = in_svc;

endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// Scoreboarded bench for irq_dispatch_ctrl: directed vectors,
// presented IDs checked by a monitor against an expected queue.
module tb_irq_dispatch_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] irq;
  logic       mask_wr;
  logic [3:0] mask_data;
  logic [3:0] pending_q;
  logic [3:0] mask_q;

  int vectors;
  int miscompares;

  logic [1:0] exp_q[$];

  irq_dispatch_ctrl_if #(.NUM_IRQ(4)) bus ();

  irq_dispatch_ctrl #(
    .NUM_IRQ (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irq       (irq),
    .mask_wr   (mask_wr),
    .mask_data (mask_data),
    .cpu       (bus),
    .pending_q (pending_q),
    .mask_q    (mask_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wr_mask(logic [3:0] m);
    mask_wr   = 1'b1;
    mask_data = m;
    tick();
    mask_wr   = 1'b0;
  endtask

  // IDLE with an enabled source pending: present, ack, eoi
  task automatic serve(string name, logic [1:0] id);
    exp_q.push_back(id);
    tick();
    check({name, "_valid"}, 32'(bus.int_valid), 32'd1);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check({name, "_ack_svc"}, 32'(bus.in_service), 32'd1);
    check({name, "_ack_val"}, 32'(bus.int_valid), 32'd0);
    bus.int_eoi = 1'b1;
    tick();
    bus.int_eoi = 1'b0;
    check({name, "_eoi_svc"}, 32'(bus.in_service), 32'd0);
    check({name, "_eoi_val"}, 32'(bus.int_valid), 32'd0);
  endtask

  // monitor: every new presentation must match the next expected ID
  logic prev_valid;
  always @(negedge clk) begin
    if (bus.int_valid && !prev_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_present: got id %0d, want none", bus.int_id);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (bus.int_id !== e) begin
          miscompares++;
          $display("FAIL present_id: got %0d, want %0d", bus.int_id, e);
        end
      end
    end
    prev_valid = bus.int_valid;
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    prev_valid  = 1'b0;
    reset       = 1'b1;
    irq         = 4'b0000;
    mask_wr     = 1'b0;
    mask_data   = 4'b0000;
    bus.int_ack = 1'b0;
    bus.int_eoi = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_valid", 32'(bus.int_valid), 32'd0);
    check("rst_id", 32'(bus.int_id), 32'd0);
    check("rst_svc", 32'(bus.in_service), 32'd0);
    check("rst_pend", 32'(pending_q), 32'd0);
    check("rst_mask", 32'(mask_q), 32'd0);

    // basic
    wr_mask(4'b1111);
    check("mask_q", 32'(mask_q), 32'hf);
    irq = 4'b0001;
    tick();
    check("basic_pend", 32'(pending_q), 32'b0001);
    check("basic_nv", 32'(bus.int_valid), 32'd0);
    serve("basic", 2'd3);
    check("basic_clr", 32'(pending_q), 32'd0);
    tick();
    check("basic_idle", 32'(bus.int_valid), 32'd0);
    irq = 4'b0000;
    tick();

    // priority
    irq = 4'b1100;
    tick();
    check("prio_pend", 32'(pending_q), 32'b1100);
    serve("prio0", 2'd0);
    check("prio_left", 32'(pending_q), 32'b0100);
    serve("prio1", 2'd1);
    check("prio_clr", 32'(pending_q), 32'd0);
    irq = 4'b0000;
    tick();

    // rotating vs fixed after IRQ0 served
    irq = 4'b1000;
    tick();
    serve("rr_a", 2'd0);
    irq = 4'b0000;
    tick();
    irq = 4'b1100;
    tick();
`ifdef IRQ_ROUND_ROBIN_EN
    serve("rr_b", 2'd1);
    serve("rr_c", 2'd0);
`else
    serve("rr_b", 2'd0);
    serve("rr_c", 2'd1);
`endif
    irq = 4'b0000;
    tick();

    // masking
    wr_mask(4'b0111);
    irq = 4'b1000;
    tick();
    check("msk_pend", 32'(pending_q), 32'b1000);
    tick();
    check("msk_nv", 32'(bus.int_valid), 32'd0);
    wr_mask(4'b1111);
    check("msk_m0", 32'(bus.int_valid), 32'd0);
    serve("msk", 2'd0);
    irq = 4'b0000;
    tick();

    // level hold
    irq = 4'b0100;
    tick();
    check("lvl_pend", 32'(pending_q), 32'b0100);
    serve("lvl_a", 2'd1);
    repeat (5) tick();
    check("lvl_nopend", 32'(pending_q), 32'd0);
    check("lvl_nv", 32'(bus.int_valid), 32'd0);
    irq = 4'b0000;
    tick();
    irq = 4'b0100;
    tick();
    serve("lvl_b", 2'd1);
    irq = 4'b0000;
    tick();

    // masked while presented: withdraw, then re-present
    irq = 4'b0001;
    tick();
    exp_q.push_back(2'd3);
    tick();
    check("wd_valid", 32'(bus.int_valid), 32'd1);
    wr_mask(4'b1110);
    check("wd_hold", 32'(bus.int_valid), 32'd1);
    tick();
    check("wd_drop", 32'(bus.int_valid), 32'd0);
    check("wd_pend", 32'(pending_q), 32'b0001);
    wr_mask(4'b1111);
    serve("wd", 2'd3);
    irq = 4'b0000;
    tick();

    // reset during SERVICE
    irq = 4'b0010;
    tick();
    exp_q.push_back(2'd2);
    tick();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check("rs_svc", 32'(bus.in_service), 32'd1);
    reset = 1'b1;
    tick();
    check("rs_valid", 32'(bus.int_valid), 32'd0);
    check("rs_id", 32'(bus.int_id), 32'd0);
    check("rs_svc0", 32'(bus.in_service), 32'd0);
    check("rs_pend", 32'(pending_q), 32'd0);
    check("rs_mask", 32'(mask_q), 32'd0);
    reset = 1'b0;
    tick();
    wr_mask(4'b1111);
    tick();
    tick();
    check("rs_nopend", 32'(pending_q), 32'd0);
    check("rs_nv", 32'(bus.int_valid), 32'd0);
    irq = 4'b0000;
    tick();
    irq = 4'b0010;
    tick();
    serve("rs", 2'd2);

    repeat (3) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_present: got %0d left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
